// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
// Optional access-error checking is enabled with the MEM_RESP_ERR_EN macro.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        MR_IDLE,
        MR_BUSY,
        MR_DONE
    } mresp_state_t;

    localparam logic [31:0] MEM_ERR_PATTERN = 32'hDEAD_BEEF;
    localparam int          MAX_WAIT        = 15;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word RAM; the read port only updates on rd_en so dout holds between reads.
// No reset on contents or on the output register.
module mem_resp_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] r_mem [2**ADDR_WIDTH];
    logic [31:0] r_dout;

    always_ff @(posedge clk) begin
        if (we)
            r_mem[idx] <= din;
        if (rd_en)
            r_dout <= r_mem[idx];
    end

    assign dout = r_dout;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory target for the multicycle MIPS core; stalls the core through clk_en.
// Define MEM_RESP_ERR_EN to flag misaligned/out-of-range accesses (sticky err, DEAD_BEEF reads).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        clk_en,
    output logic        err
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    mresp_state_t r_state, w_next;
    logic [3:0]   r_cnt;
    logic [31:0]  r_addr, r_wdata;
    logic         r_we;
    logic         r_err, r_rd_vld, r_rd_err;
    logic         w_last, w_acc_err, w_ram_we, w_ram_rd;
    logic [31:0]  w_dout;

`ifdef MEM_RESP_ERR_EN
    assign w_acc_err = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_WIDTH+2] != '0);
`else
    logic [ADDR_WIDTH-1:0] w_unused_addr;
    assign w_unused_addr = {{(ADDR_WIDTH-2){1'b0}}, r_addr[1:0]} ^ r_addr[31:ADDR_WIDTH+2];
    assign w_acc_err     = 1'b0;
`endif

    assign w_last   = (r_state == MR_BUSY) && (r_cnt == 4'd0);
    assign w_ram_we = w_last && r_we && !w_acc_err;
    assign w_ram_rd = w_last && !r_we && !w_acc_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= MR_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        clk_en = 1'b0;
        case (r_state)
            MR_IDLE: begin
                clk_en = ~req;
                if (req)
                    w_next = MR_BUSY;
            end
            MR_BUSY: begin
                if (r_cnt == 4'd0)
                    w_next = MR_DONE;
            end
            MR_DONE: begin
                clk_en = 1'b1;
                w_next = MR_IDLE;
            end
            default: w_next = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (r_state == MR_IDLE && req) begin
                r_addr  <= addr;
                r_we    <= we;
                r_wdata <= wdata;
                r_cnt   <= CNT_INIT;
            end else if (r_state == MR_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Read completion: the RAM output register carries good data, the flag selects the error pattern.
            if (w_last && !r_we) begin
                r_rd_vld <= 1'b1;
                r_rd_err <= w_acc_err;
            end
            if (w_last && w_acc_err)
                r_err <= 1'b1;
        end
    end

    mem_resp_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .we    (w_ram_we),
        .rd_en (w_ram_rd),
        .idx   (r_addr[ADDR_WIDTH+1:2]),
        .din   (r_wdata),
        .dout  (w_dout)
    );

    assign rdata = !r_rd_vld ? 32'h0 : (r_rd_err ? MEM_ERR_PATTERN : w_dout);
    assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: dut (WAIT_CYCLES=2) for directed tests, dut1 (WAIT_CYCLES=1) for the random sweep.
module tb_mem_responder;

    localparam logic [31:0] PATTERN = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0, we0, clk_en0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, clk_en1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .clk_en(clk_en0), .err(err0)
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .clk_en(clk_en1), .err(err1)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model0 [1024];
    logic [31:0] model1 [1024];
    logic        merr [2];
    logic [31:0] sb_q [$];

    function automatic logic acc_err(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
        return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic get_ce(input int sel);
        return (sel != 0) ? clk_en1 : clk_en0;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel != 0) ? rdata1 : rdata0;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel != 0) ? err1 : err0;
    endfunction

    task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (sel != 0) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Starts at posedge+1 with the DUT in IDLE; returns at posedge+1 after DONE, req left asserted.
    task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        int          stalls = 0;
        int          exp_st;
        bit          done = 0;
        logic        e;
        logic [31:0] prev, exp_rd;
        e      = acc_err(a);
        prev   = get_rd(sel);
        exp_st = ((sel != 0) ? 1 : 2) + 1;
        if (!w)
            sb_q.push_back(e ? PATTERN : ((sel != 0) ? model1[a[11:2]] : model0[a[11:2]]));
        else if (!e) begin
            if (sel != 0) model1[a[11:2]] = d;
            else          model0[a[11:2]] = d;
        end
        if (e) merr[sel] = 1'b1;
        drive(sel, 1'b1, w, a, d);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (get_ce(sel)) done = 1;
            else             stalls++;
        end
        n_checks++;
        if (!done || stalls != exp_st) begin
            n_fail++;
            $display("FAIL %s stalls: got %0d (done=%0d) want %0d", tag, stalls, done, exp_st);
        end
        if (!w) exp_rd = sb_q.pop_front();
        else    exp_rd = prev;
        if (done) begin
            n_checks++;
            if (get_rd(sel) !== exp_rd) begin
                n_fail++;
                $display("FAIL %s rdata: got %h want %h", tag, get_rd(sel), exp_rd);
            end
            n_checks++;
            if (get_err(sel) !== merr[sel]) begin
                n_fail++;
                $display("FAIL %s err: got %b want %b", tag, get_err(sel), merr[sel]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        merr[0] = 1'b0; merr[1] = 1'b0;
        #12;
        n_checks++;
        if (rdata0 !== 32'h0 || err0 !== 1'b0 || clk_en0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset dut: rdata=%h err=%b clk_en=%b want 0/0/1", rdata0, err0, clk_en0);
        end
        n_checks++;
        if (rdata1 !== 32'h0 || err1 !== 1'b0 || clk_en1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset dut1: rdata=%h err=%b clk_en=%b want 0/0/1", rdata1, err1, clk_en1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; #1;
        n_checks++;
        if (clk_en0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_req clk_en: got %b want 0", clk_en0);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch;
        access(0, 1'b1, 32'h0000_000C, 32'h2008_0005, "preload");
        access(0, 1'b0, 32'h0000_000C, 32'h0, "fetch");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (clk_en0 !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_idle clk_en: got %b want 1", clk_en0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        access(0, 1'b0, 32'h0000_000C, 32'h0, "sl_read0");
        access(0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, "sl_write");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (rdata0 !== 32'h2008_0005) begin
            n_fail++;
            $display("FAIL sl_after_write rdata: got %h want 20080005", rdata0);
        end
        @(posedge clk); #1;
        access(0, 1'b0, 32'h0000_0040, 32'h0, "sl_read40");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        access(0, 1'b0, 32'h0000_000C, 32'h0, "b2b_first");
        access(0, 1'b0, 32'h0000_0040, 32'h0, "b2b_second");
        access(0, 1'b1, 32'h0000_0044, 32'h5555_AAAA, "b2b_write");
        access(0, 1'b0, 32'h0000_0044, 32'h0, "b2b_read");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write;
        access(0, 1'b1, 32'h0000_0010, 32'h1111_1111, "rmw_init");
        access(0, 1'b0, 32'h0000_0010, 32'h0, "rmw_check_init");
        drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'h2222_2222);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        n_checks++;
        if (clk_en0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw clk_en req=1: got %b want 0", clk_en0);
        end
        req0 = 1'b0; #1;
        n_checks++;
        if (clk_en0 !== 1'b1 || rdata0 !== 32'h0 || err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw after reset: clk_en=%b rdata=%h err=%b want 1/0/0", clk_en0, rdata0, err0);
        end
        merr[0] = 1'b0; merr[1] = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        access(0, 1'b0, 32'h0000_0010, 32'h0, "rmw_not_committed");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_err;
        access(0, 1'b1, 32'h0000_0000, 32'h1234_5678, "err_init");
        access(0, 1'b0, 32'h0000_0002, 32'h0, "err_misaligned_read");
        access(0, 1'b1, 32'h0001_0000, 32'hBBBB_BBBB, "err_range_write");
        access(0, 1'b0, 32'h0000_0000, 32'h0, "err_alias_read");
        access(0, 1'b0, 32'h0000_000E, 32'h0, "err_unaligned_0E");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_checks++;
        if (err0 !== merr[0]) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want %b", err0, merr[0]);
        end
    endtask

    task automatic test_sweep;
        logic [31:0] a;
        for (int i = 0; i < 16; i++)
            access(1, 1'b1, 32'(i) << 2, $urandom, "sweep_init");
        for (int i = 0; i < 100; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            access(1, 1'($urandom_range(0, 1)), a, $urandom, "sweep");
            if ($urandom_range(0, 3) == 0) begin
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
                @(posedge clk); #1;
            end
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_load;
        test_back_to_back;
        test_reset_mid_write;
        test_err;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
